axi_master_arbiter_r: RTL and testbench
=======================================

# axi_master_arbiter_r

Read-channel counterpart of the two-master AXI4 write mux. It arbitrates the AR channels of two AXI4 masters onto one shared slave-side read path and routes the returned R beats back to the owning master. A registered grant is held from AR acceptance until the RLAST handshake, so every read burst completes atomically. It sits between master 0/1 read ports and the slave-side address decoder in the AXI interconnect.

## Interface
- DATA_WIDTH, 32, RDATA width
- ADDR_WIDTH, 32, ARADDR width
- ID_WIDTH, 1, ARID/RID width
- USER_WIDTH, 1, ARUSER/RUSER width
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- mN_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AR payload of master N (N=0,1)
- mN_ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  in  1/4/3/4/4/USER_WIDTH  AR attributes of master N
- mN_ARVALID  in  1  read request of master N
- mN_ARREADY  out  1  AR accept to master N
- mN_RID/RDATA/RRESP/RLAST/RUSER  out  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH  R beat to master N
- mN_RVALID  out  1  R beat valid to master N
- mN_RREADY  in  1  R accept from master N
- s_AR* (same set as mN_AR*, incl. s_ARVALID)  out  as above  muxed AR toward slave side
- s_ARREADY  in  1  slave-side AR accept
- s_RID/RDATA/RRESP/RLAST/RUSER/RVALID  in  as above  slave-side R beat
- s_RREADY  out  1  muxed R accept
- m0_rgrnt, m1_rgrnt  out  1 each  registered one-hot grant

## Operation
- States: IDLE, ADDR, DATA. Registers: state, grant[1:0] (one-hot or zero), last_owner.
- IDLE: grant=00. If any mN_ARVALID: pick winner, load grant, go ADDR. Else stay.
- Winner: only one valid → that one; both valid → master != last_owner.
- ADDR: s_AR* = granted master's AR*; mN_ARREADY = s_ARREADY for the granted master only. On s_ARVALID & s_ARREADY → DATA.
- DATA: s_AR* driven to 0 (s_ARVALID=0). Granted master: mN_R* = s_R*, mN_RVALID = s_RVALID, s_RREADY = mN_RREADY. On s_RVALID & s_RREADY & s_RLAST → IDLE, last_owner ← granted index, grant ← 00.
- Non-granted master: ARREADY=0, RVALID=0, R payload 0. grant=00: all s_* outputs 0.
- Granted master deasserting ARVALID in ADDR (protocol violation): stay in ADDR, forward as-is; no regrant.
- R beats with RLAST=0 keep DATA; ARLEN is not counted, RLAST alone ends the burst.

## Timing
- Reset: state=IDLE, grant=00, last_owner=1 (m0 wins first tie); all outputs 0.
- Arbitration latency: ARVALID in cycle t (IDLE) → rgrnt and s_ARVALID high in t+1.
- Earliest AR accept: t+1 if s_ARREADY high. DATA from t+2.
- All mux paths from the grant register are combinational: zero-cycle ready/valid/data forwarding in ADDR and DATA.
- RLAST handshake in cycle u → IDLE at u+1 → next grant at u+2; one dead cycle between bursts.
- ARESET mid-burst: next cycle IDLE, grant=00, last_owner=1; in-flight beats are dropped (system-level reset).

## Configuration
- AXI_RD_ARB_RR_EN defined: round-robin tie-break via last_owner as above.
- Not defined: fixed priority, m0 always wins ties; last_owner is not implemented; all other behaviour identical.

## Test plan
- Single m0 read: ARADDR=0x1000, ARLEN=3, s_ARREADY=1 → m0_rgrnt at t+1, AR accepted t+1, 4 RDATA beats reach only m0; m1_RVALID stays 0; IDLE after RLAST.
- Simultaneous requests after reset, both ARVALID at t → m0 granted first; after its RLAST, m1 granted. With macro off → m0 granted again if still requesting.
- Back-pressure: s_ARREADY low 3 cycles, m0_RREADY toggling → no beat lost or duplicated; grant held throughout.
- m1 raises ARVALID during m0's DATA phase → m1_ARREADY=0 until m0's RLAST; m1 granted in the cycle after IDLE.
- ARESET asserted mid-burst (beat 2 of 4) → next cycle grant=00, all outputs 0; fresh m1 request is then granted normally.

Source files
------------

// File: rtl/axi_master_arbiter_r_if.sv
// AXI4 read-address/read-data channel bundle shared by the two-master read arbiter.
// 'master' is the side that issues AR and accepts R; 'slave' is the side that answers.
interface axi_master_arbiter_r_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic [3:0]            ARREGION;
  logic [USER_WIDTH-1:0] ARUSER;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [USER_WIDTH-1:0] RUSER;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION,
           ARUSER, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
  );
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION,
           ARUSER, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
  );
endinterface

// File: rtl/axi_master_arbiter_r.sv
// Two-master AXI4 read arbiter: grant held from AR accept through RLAST handshake.
// Define AXI_RD_ARB_RR_EN for round-robin tie-break; otherwise m0 wins ties.
module axi_master_arbiter_r #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi_master_arbiter_r_if.slave  m0,
  axi_master_arbiter_r_if.slave  m1,
  axi_master_arbiter_r_if.master s,
  output logic                   m0_rgrnt,
  output logic                   m1_rgrnt
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
  } ar_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
  } r_t;

  state_t        state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic [1:0]    req, m_rready, ar_rdy;
  logic          r_rdy, pick_m0, tie_m0, rlast_hs;
  ar_t [1:0]     m_ar;
  ar_t           s_ar;
  r_t            s_r;
  r_t [1:0]      m_r;

  assign m_ar[0] = {m0.ARID, m0.ARADDR, m0.ARLEN, m0.ARSIZE, m0.ARBURST, m0.ARLOCK,
                    m0.ARCACHE, m0.ARPROT, m0.ARQOS, m0.ARREGION, m0.ARUSER, m0.ARVALID};
  assign m_ar[1] = {m1.ARID, m1.ARADDR, m1.ARLEN, m1.ARSIZE, m1.ARBURST, m1.ARLOCK,
                    m1.ARCACHE, m1.ARPROT, m1.ARQOS, m1.ARREGION, m1.ARUSER, m1.ARVALID};
  assign s_r      = {s.RID, s.RDATA, s.RRESP, s.RLAST, s.RUSER, s.RVALID};
  assign req      = {m1.ARVALID, m0.ARVALID};
  assign m_rready = {m1.RREADY, m0.RREADY};
  assign rlast_hs = s.RVALID & r_rdy & s.RLAST;

`ifdef AXI_RD_ARB_RR_EN
  logic last_owner;  // 1 = m1 owned the last burst, so m0 wins the next tie

  always_ff @(posedge ACLK) begin
    if (ARESET)                        last_owner <= 1'b1;
    else if (state == DATA && rlast_hs) last_owner <= grant[1];
  end

  assign tie_m0 = last_owner;
`else
  assign tie_m0 = 1'b1;
`endif

  assign pick_m0 = req[0] & (~req[1] | tie_m0);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // ARLEN is deliberately ignored: only the RLAST handshake releases the grant.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: if (|req) begin
        grant_nxt = pick_m0 ? 2'b01 : 2'b10;
        state_nxt = ADDR;
      end
      ADDR: if (s_ar.valid && s.ARREADY) state_nxt = DATA;
      DATA: if (rlast_hs) begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  // Zero-cycle forwarding; everything not owned by the grant holder is held at 0.
  always_comb begin
    s_ar   = '0;
    m_r    = '0;
    ar_rdy = 2'b00;
    r_rdy  = 1'b0;
    case (state)
      ADDR: begin
        s_ar   = grant[1] ? m_ar[1] : m_ar[0];
        ar_rdy = grant & {2{s.ARREADY}};
      end
      DATA: begin
        for (int i = 0; i < 2; i++)
          if (grant[i]) m_r[i] = s_r;
        r_rdy = |(grant & m_rready);
      end
      default: ;
    endcase
  end

  assign {s.ARID, s.ARADDR, s.ARLEN, s.ARSIZE, s.ARBURST, s.ARLOCK, s.ARCACHE, s.ARPROT,
          s.ARQOS, s.ARREGION, s.ARUSER, s.ARVALID} = s_ar;
  assign s.RREADY   = r_rdy;
  assign m0.ARREADY = ar_rdy[0];
  assign m1.ARREADY = ar_rdy[1];
  assign {m0.RID, m0.RDATA, m0.RRESP, m0.RLAST, m0.RUSER, m0.RVALID} = m_r[0];
  assign {m1.RID, m1.RDATA, m1.RRESP, m1.RLAST, m1.RUSER, m1.RVALID} = m_r[1];
  assign m0_rgrnt = grant[0];
  assign m1_rgrnt = grant[1];
endmodule

// File: tb/tb_axi_master_arbiter_r.sv
// Bench for axi_master_arbiter_r: ownership-level model checked every cycle plus directed scenarios.
module tb_axi_master_arbiter_r;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic m0_rgrnt, m1_rgrnt;
  always #5 ACLK = ~ACLK;

  axi_master_arbiter_r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) m0_if ();
  axi_master_arbiter_r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) m1_if ();
  axi_master_arbiter_r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) s_if ();

  axi_master_arbiter_r #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .m0(m0_if), .m1(m1_if), .s(s_if),
    .m0_rgrnt(m0_rgrnt), .m1_rgrnt(m1_rgrnt)
  );

  int n_chk = 0, n_pass = 0;
  logic [31:0] rx0[$], rx1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: who owns the slave path, and whether its address has been taken yet.
  int owner = -1;
  bit acc = 0;
  int last_own = 1;
  bit mdl_on = 0;

  function automatic int tie_winner(input int lo);
`ifdef AXI_RD_ARB_RR_EN
    return (lo == 0) ? 1 : 0;
`else
    return (lo < 0) ? 1 : 0;  // fixed priority: m0 always
`endif
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      owner <= -1; acc <= 0; last_own <= 1; mdl_on <= 1;
    end else if (owner < 0) begin
      if (m0_if.ARVALID && m1_if.ARVALID) owner <= tie_winner(last_own);
      else if (m0_if.ARVALID) owner <= 0;
      else if (m1_if.ARVALID) owner <= 1;
    end else if (!acc) begin
      if (((owner == 0) ? m0_if.ARVALID : m1_if.ARVALID) && s_if.ARREADY) acc <= 1;
    end else if (s_if.RVALID && s_if.RLAST && ((owner == 0) ? m0_if.RREADY : m1_if.RREADY)) begin
      last_own <= owner; owner <= -1; acc <= 0;
    end
  end

  always @(negedge ACLK) begin
    logic [1:0]  eg;
    logic [41:0] ear, m0ar, m1ar;
    logic [33:0] er0, er1, sr;
    bit ap, dp;
    if (mdl_on) begin
      ap   = (owner >= 0) && !acc;
      dp   = (owner >= 0) && acc;
      eg   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      m0ar = {m0_if.ARVALID, m0_if.ARADDR, m0_if.ARLEN, m0_if.ARID};
      m1ar = {m1_if.ARVALID, m1_if.ARADDR, m1_if.ARLEN, m1_if.ARID};
      ear  = !ap ? '0 : (owner == 0) ? m0ar : m1ar;
      sr   = {s_if.RVALID, s_if.RLAST, s_if.RDATA};
      er0  = (dp && owner == 0) ? sr : '0;
      er1  = (dp && owner == 1) ? sr : '0;
      chk("mdl_grant", {m1_rgrnt, m0_rgrnt}, eg);
      chk("mdl_s_ar", {s_if.ARVALID, s_if.ARADDR, s_if.ARLEN, s_if.ARID}, ear);
      chk("mdl_arready", {m1_if.ARREADY, m0_if.ARREADY},
          {ap && owner == 1 && s_if.ARREADY, ap && owner == 0 && s_if.ARREADY});
      chk("mdl_m0_r", {m0_if.RVALID, m0_if.RLAST, m0_if.RDATA}, er0);
      chk("mdl_m1_r", {m1_if.RVALID, m1_if.RLAST, m1_if.RDATA}, er1);
      chk("mdl_s_rready", s_if.RREADY, dp && ((owner == 0) ? m0_if.RREADY : m1_if.RREADY));
      if (m0_if.RVALID && m0_if.RREADY) rx0.push_back(m0_if.RDATA);
      if (m1_if.RVALID && m1_if.RREADY) rx1.push_back(m1_if.RDATA);
    end
  end

  task automatic set_req(input int m, input logic v, input logic [31:0] addr, input logic [7:0] len);
    if (m == 0) begin m0_if.ARVALID = v; m0_if.ARADDR = addr; m0_if.ARLEN = len; end
    else        begin m1_if.ARVALID = v; m1_if.ARADDR = addr; m1_if.ARLEN = len; end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the last handshake.
  task automatic r_beats(input int n, input logic [31:0] base, input bit tog);
    int i = 0, g = 0;
    while (i < n && g < 200) begin
      s_if.RVALID = 1'b1; s_if.RDATA = base + i; s_if.RLAST = (i == n - 1);
      if (tog) m0_if.RREADY = (g % 2) == 1;
      @(negedge ACLK);
      if (s_if.RREADY) i++;
      @(posedge ACLK); #1;
      g++;
    end
    s_if.RVALID = 1'b0; s_if.RLAST = 1'b0; s_if.RDATA = '0; m0_if.RREADY = 1'b1;
    chk("r_beats_done", i, n);
  endtask

  task automatic serve(input int m, input int n, input logic [31:0] base, input bit tog, input bit at_neg);
    int g = 0;
    logic rdy;
    if (!at_neg) @(negedge ACLK);
    rdy = (m == 0) ? m0_if.ARREADY : m1_if.ARREADY;
    while (!rdy && g < 50) begin
      @(posedge ACLK); #1; @(negedge ACLK);
      rdy = (m == 0) ? m0_if.ARREADY : m1_if.ARREADY;
      g++;
    end
    chk("ar_accept", rdy, 1'b1);
    @(posedge ACLK); #1;
    if (m == 0) m0_if.ARVALID = 1'b0; else m1_if.ARVALID = 1'b0;
    r_beats(n, base, tog);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    rx0.delete(); rx1.delete();
  endtask

  initial begin
    int w;
    {m0_if.ARID, m0_if.ARSIZE, m0_if.ARBURST, m0_if.ARLOCK, m0_if.ARCACHE, m0_if.ARPROT,
     m0_if.ARQOS, m0_if.ARREGION, m0_if.ARUSER} = '0;
    {m1_if.ARSIZE, m1_if.ARBURST, m1_if.ARLOCK, m1_if.ARCACHE, m1_if.ARPROT,
     m1_if.ARQOS, m1_if.ARREGION, m1_if.ARUSER} = '0;
    m1_if.ARID = 1'b1;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    m0_if.RREADY = 1'b1; m1_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b1;
    {s_if.RID, s_if.RDATA, s_if.RRESP, s_if.RLAST, s_if.RUSER, s_if.RVALID} = '0;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("rst_grant", {m1_rgrnt, m0_rgrnt}, 2'b00);
    chk("rst_s_arvalid", s_if.ARVALID, 1'b0);
    chk("rst_s_rready", s_if.RREADY, 1'b0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Single m0 read, ARLEN=3
    set_req(0, 1, 32'h1000, 8'd3);
    @(negedge ACLK);
    chk("t1_no_grant_yet", m0_rgrnt, 1'b0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t1_grant", {m1_rgrnt, m0_rgrnt}, 2'b01);
    chk("t1_s_arvalid", s_if.ARVALID, 1'b1);
    chk("t1_s_araddr", s_if.ARADDR, 32'h1000);
    chk("t1_m0_arready", m0_if.ARREADY, 1'b1);
    @(posedge ACLK); #1;
    m0_if.ARVALID = 1'b0;
    r_beats(4, 32'hA0, 0);
    chk("t1_rx0_cnt", rx0.size(), 4);
    for (int k = 0; k < 4 && k < rx0.size(); k++) chk("t1_rx0_data", rx0[k], 32'hA0 + k);
    chk("t1_rx1_cnt", rx1.size(), 0);
    @(negedge ACLK);
    chk("t1_idle_grant", {m1_rgrnt, m0_rgrnt}, 2'b00);
    @(posedge ACLK); #1;

    // Simultaneous requests after reset
    do_reset();
    set_req(0, 1, 32'h2000, 8'd1); set_req(1, 1, 32'h3000, 8'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t2_first_tie", {m1_rgrnt, m0_rgrnt}, 2'b01);
    serve(0, 2, 32'hB0, 0, 1);
    chk("t2_rx0_cnt", rx0.size(), 2);
    set_req(0, 1, 32'h2100, 8'd0);
    @(negedge ACLK);
    chk("t2_dead_cycle", {m1_rgrnt, m0_rgrnt}, 2'b00);
    @(posedge ACLK); #1;
    @(negedge ACLK);
`ifdef AXI_RD_ARB_RR_EN
    w = 1;
`else
    w = 0;
`endif
    chk("t2_second_tie", {m1_rgrnt, m0_rgrnt}, (w == 1) ? 2'b10 : 2'b01);
    serve(w, 1, 32'hC0, 0, 1);
    serve(1 - w, 1, 32'hD0, 0, 0);
    chk("t2_rx1_cnt", rx1.size(), 1);
    if (rx1.size() > 0) chk("t2_rx1_data", rx1[0], (w == 1) ? 32'hC0 : 32'hD0);

    // Address back-pressure plus toggling RREADY
    rx0.delete();
    s_if.ARREADY = 1'b0;
    set_req(0, 1, 32'h4000, 8'd3);
    @(posedge ACLK); #1;
    repeat (3) begin
      @(negedge ACLK);
      chk("t3_hold_grant", m0_rgrnt, 1'b1);
      chk("t3_arready_low", m0_if.ARREADY, 1'b0);
      @(posedge ACLK); #1;
    end
    s_if.ARREADY = 1'b1;
    serve(0, 4, 32'hE0, 1, 0);
    chk("t3_rx0_cnt", rx0.size(), 4);
    for (int k = 0; k < 4 && k < rx0.size(); k++) chk("t3_rx0_data", rx0[k], 32'hE0 + k);

    // m1 requests while m0 is in its data phase
    rx1.delete();
    set_req(0, 1, 32'h5000, 8'd2);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t4_m0_grant", m0_rgrnt, 1'b1);
    @(posedge ACLK); #1;
    m0_if.ARVALID = 1'b0;
    set_req(1, 1, 32'h6000, 8'd1);
    @(negedge ACLK);
    chk("t4_m1_blocked", m1_if.ARREADY, 1'b0);
    chk("t4_m1_nogrant", m1_rgrnt, 1'b0);
    @(posedge ACLK); #1;
    r_beats(3, 32'hF0, 0);
    @(negedge ACLK);
    chk("t4_m1_dead", m1_rgrnt, 1'b0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t4_m1_grant", m1_rgrnt, 1'b1);
    serve(1, 2, 32'h60, 0, 1);
    chk("t4_rx1_cnt", rx1.size(), 2);
    if (rx1.size() == 2) chk("t4_rx1_last", rx1[1], 32'h61);

    // Reset in the middle of a 4-beat burst
    set_req(0, 1, 32'h7000, 8'd3);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    m0_if.ARVALID = 1'b0;
    s_if.RVALID = 1'b1; s_if.RDATA = 32'h71; s_if.RLAST = 1'b0;
    @(posedge ACLK); #1;
    s_if.RDATA = 32'h72;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("t5_grant", {m1_rgrnt, m0_rgrnt}, 2'b00);
    chk("t5_m0_rvalid", m0_if.RVALID, 1'b0);
    chk("t5_s_rready", s_if.RREADY, 1'b0);
    chk("t5_s_arvalid", s_if.ARVALID, 1'b0);
    @(posedge ACLK); #1;
    s_if.RVALID = 1'b0; s_if.RDATA = '0;
    rx1.delete();
    set_req(1, 1, 32'h8000, 8'd0);
    serve(1, 1, 32'h81, 0, 0);
    chk("t5_rx1_cnt", rx1.size(), 1);
    if (rx1.size() > 0) chk("t5_rx1_data", rx1[0], 32'h81);

    repeat (2) @(posedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
